adder_3op_feeder: RTL and testbench

Stream-to-operand front end for the 3-operand 16-bit ripple-carry adder. Accepts a valid/ready stream of W-bit words, packs each group of three into a stable A/B/C/Cin operand set, drives the combinational adder for one evaluation cycle, and captures its W+1-bit sum into a result register with a valid/ready output handshake. It also keeps an internal wide shadow sum, which it uses to flag true-sum overflow of the adder's W+1-bit result and to flag a mismatch against the adder's output.

---
 rtl/adder_3op_feeder_if.sv | 32 +++
 rtl/adder_3op_feeder.sv | 120 ++++++++++++
 tb/tb_adder_3op_feeder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/adder_3op_feeder_if.sv
// Stream/operand/result bundle between adder_3op_feeder and its environment
// (word source, combinational 3-operand adder, result consumer).
interface adder_3op_feeder_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         cin_cfg;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] C;
  logic         Cin;
  logic [W:0]   S;
  logic         res_valid;
  logic         res_ready;
  logic [W:0]   res_sum;
  logic [1:0]   res_cnt;
  logic         res_ovf;
  logic         res_err;

  modport master (
    output in_valid, in_data, in_last, cin_cfg, S, res_ready,
    input  in_ready, A, B, C, Cin, res_valid, res_sum, res_cnt, res_ovf, res_err
  );

  modport slave (
    input  in_valid, in_data, in_last, cin_cfg, S, res_ready,
    output in_ready, A, B, C, Cin, res_valid, res_sum, res_cnt, res_ovf, res_err
  );
endinterface

// File: rtl/adder_3op_feeder.sv
// Packs up to three stream words into stable adder operands, evaluates for one
// cycle, then captures the adder sum with overflow/consistency flags.
module adder_3op_feeder #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  adder_3op_feeder_if.slave   bus
);

  typedef enum logic [2:0] {GET0, GET1, GET2, EVAL, OUT} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic           cin_q, cin_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [W:0]     sum_q, sum_d;
  logic [1:0]     rcnt_q, rcnt_d;
  logic           ovf_q, ovf_d, err_q, err_d;
  logic [W+1:0]   shadow;
  logic           accept;

  assign accept = bus.in_valid && bus.in_ready;
  // Two guard bits: three full operands plus carry can reach 3*(2^W-1)+1.
  assign shadow = {2'b00, a_q} + {2'b00, b_q} + {2'b00, c_q}
                + {{(W+1){1'b0}}, cin_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= GET0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GET0:    if (accept) state_d = bus.in_last ? EVAL : GET1;
      GET1:    if (accept) state_d = bus.in_last ? EVAL : GET2;
      GET2:    if (accept) state_d = EVAL;
      EVAL:    state_d = OUT;
      OUT:     if (bus.res_ready) state_d = GET0;
      default: state_d = GET0;
    endcase
  end

  // in_ready is held low while reset is asserted even though the state is GET0.
  always_comb begin
    bus.in_ready  = rst_n && (state_q inside {GET0, GET1, GET2});
    bus.res_valid = (state_q == OUT);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    cin_d  = cin_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    rcnt_d = rcnt_q;
    ovf_d  = ovf_q;
    err_d  = err_q;
    case (state_q)
      GET0: if (accept) begin
        a_d   = bus.in_data;
        cin_d = bus.cin_cfg;
        b_d   = '0;
        c_d   = '0;
        if (bus.in_last) cnt_d = 2'd1;
      end
      GET1: if (accept) begin
        b_d = bus.in_data;
        if (bus.in_last) cnt_d = 2'd2;
      end
      GET2: if (accept) begin
        c_d   = bus.in_data;
        cnt_d = 2'd3;
      end
      EVAL: begin
        sum_d  = bus.S;
        ovf_d  = shadow[W+1];
        err_d  = (bus.S != shadow[W:0]);
        rcnt_d = cnt_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      cin_q  <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      rcnt_q <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      cin_q  <= cin_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      rcnt_q <= rcnt_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
    end
  end

  assign bus.A       = a_q;
  assign bus.B       = b_q;
  assign bus.C       = c_q;
  assign bus.Cin     = cin_q;
  assign bus.res_sum = sum_q;
  assign bus.res_cnt = rcnt_q;
  assign bus.res_ovf = ovf_q;
  assign bus.res_err = err_q;

endmodule

// File: tb/tb_adder_3op_feeder.sv
// Bench for adder_3op_feeder: directed vector table, reset/backpressure
// sequences and random groups checked against an arithmetic reference.
module tb_adder_3op_feeder;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic fault;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  adder_3op_feeder_if #(.W(W)) bus ();

  // External combinational adder; fault forces its output to zero.
  assign bus.S = fault ? '0
               : ({1'b0, bus.A} + {1'b0, bus.B} + {1'b0, bus.C} + {{W{1'b0}}, bus.Cin});

  adder_3op_feeder #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [W-1:0] w0, w1, w2;
    int           n;
    logic         cin;
    logic         flt;
    int           hold;
    logic [W:0]   es;
    logic [1:0]   ec;
    logic         eo;
    logic         ee;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  0);
    check({tag, "_A"},         32'(bus.A),         0);
    check({tag, "_B"},         32'(bus.B),         0);
    check({tag, "_C"},         32'(bus.C),         0);
    check({tag, "_Cin"},       32'(bus.Cin),       0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 0);
    check({tag, "_res_sum"},   32'(bus.res_sum),   0);
    check({tag, "_res_cnt"},   32'(bus.res_cnt),   0);
    check({tag, "_res_ovf"},   32'(bus.res_ovf),   0);
    check({tag, "_res_err"},   32'(bus.res_err),   0);
  endtask

  task automatic run_group(input logic [W-1:0] w0, w1, w2, input int n, input logic cin,
                           input logic flt, input int hold, input logic [W:0] es,
                           input logic [1:0] ec, input logic eo, input logic ee);
    logic [W-1:0] w[3];
    w = '{w0, w1, w2};
    fault = flt;
    bus.res_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("in_ready_get", 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = w[i];
      bus.in_last  = (i == n - 1) ? ((n < 3) ? 1'b1 : 1'($urandom % 2)) : 1'b0;
      bus.cin_cfg  = (i == 0) ? cin : 1'($urandom % 2);
    end
    @(negedge clk);
    check("eval_in_ready",  32'(bus.in_ready),  0);
    check("eval_res_valid", 32'(bus.res_valid), 0);
    check("op_A",   32'(bus.A),   32'(w0));
    check("op_B",   32'(bus.B),   (n >= 2) ? 32'(w1) : 0);
    check("op_C",   32'(bus.C),   (n == 3) ? 32'(w2) : 0);
    check("op_Cin", 32'(bus.Cin), 32'(cin));
    bus.in_valid = 1'($urandom % 2);
    bus.in_data  = W'($urandom);
    @(negedge clk);
    check("out_res_valid", 32'(bus.res_valid), 1);
    check("res_sum", 32'(bus.res_sum), 32'(es));
    check("res_cnt", 32'(bus.res_cnt), 32'(ec));
    check("res_ovf", 32'(bus.res_ovf), 32'(eo));
    check("res_err", 32'(bus.res_err), 32'(ee));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hBEEF;
      @(negedge clk);
      check("hold_in_ready",  32'(bus.in_ready),  0);
      check("hold_res_valid", 32'(bus.res_valid), 1);
      check("hold_res_sum",   32'(bus.res_sum),   32'(es));
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("post_res_valid", 32'(bus.res_valid), 0);
    check("post_in_ready",  32'(bus.in_ready),  1);
    check("post_A_held",    32'(bus.A),         32'(w0));
  endtask

  initial begin
    tbl[0] = '{16'h0001, 16'h0001, 16'h0001, 3, 1'b0, 1'b0, 0, 17'h00003, 2'd3, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 3, 1'b1, 1'b0, 0, 17'h0FFFE, 2'd3, 1'b1, 1'b0};
    tbl[2] = '{16'd12345, 16'd54321, 16'd0, 2, 1'b0, 1'b0, 0, 17'd66666, 2'd2, 1'b0, 1'b0};
    tbl[3] = '{16'd100, 16'd200, 16'd300, 3, 1'b0, 1'b0, 4, 17'd600, 2'd3, 1'b0, 1'b0};
    tbl[4] = '{16'd1, 16'd2, 16'd3, 3, 1'b0, 1'b1, 0, 17'd0, 2'd3, 1'b0, 1'b1};
    tbl[5] = '{16'hFFFF, 16'd0, 16'd0, 1, 1'b1, 1'b0, 0, 17'h10000, 2'd1, 1'b0, 1'b0};

    rst_n = 1'b0;
    fault = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.cin_cfg   = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", 32'(bus.in_ready), 1);

    for (int i = 0; i < 6; i++)
      run_group(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].n, tbl[i].cin, tbl[i].flt,
                tbl[i].hold, tbl[i].es, tbl[i].ec, tbl[i].eo, tbl[i].ee);

    // Reset after two accepted words of a group.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd500;
    bus.in_last  = 1'b0;
    bus.cin_cfg  = 1'b1;
    @(negedge clk);
    bus.in_data  = 16'd600;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_group(16'd40000, 16'd25535, 16'd1000, 3, 1'b0, 1'b0, 0, 17'd66535, 2'd3, 1'b0, 1'b0);

    // Random groups against the arithmetic reference.
    for (int r = 0; r < 40; r++) begin
      logic [W-1:0] a, b, c;
      int           n;
      logic         cin, flt;
      longint       tot;
      logic [W:0]   es;
      a   = ($urandom % 4 == 0) ? 16'hFFFF : W'($urandom);
      b   = ($urandom % 4 == 0) ? 16'hFFFF : W'($urandom);
      c   = ($urandom % 4 == 0) ? 16'hFFFF : W'($urandom);
      n   = int'($urandom_range(1, 3));
      cin = 1'($urandom % 2);
      flt = ($urandom % 8 == 0);
      tot = longint'(a) + ((n > 1) ? longint'(b) : 0) + ((n > 2) ? longint'(c) : 0) + longint'(cin);
      es  = flt ? '0 : (W+1)'(tot % (longint'(1) << (W + 1)));
      run_group(a, b, c, n, cin, flt, int'($urandom_range(0, 2)), es, 2'(n),
                tot >= (longint'(1) << (W + 1)),
                flt && ((tot % (longint'(1) << (W + 1))) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
